// File: rtl/clock_gate_ctrl.sv
// Idle-driven sequencer for a single ICG cell: counts idle cycles, drains the
// gated domain, drops the clock enable, and restores it on wake with a settle window.

module clock_gate_ctrl_chk (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_drain_ack,
   input  logic i_in_drain
);

   // Simulation-only flag for a drain acknowledge arriving outside DRAIN
   a_ack_only_in_drain : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_drain_ack |-> i_in_drain)
      else $warning("drain_ack_i asserted outside DRAIN; ignored");

endmodule

module clock_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic test_mode_i,
   input  logic busy_i,
   input  logic wake_req_i,
   output logic drain_req_o,
   input  logic drain_ack_i,
   output logic clk_en_o,
   output logic test_en_o,
   output logic gated_o,
   output logic ready_o
);

   localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   // WAKE_CYCLES=0 and 1 both leave WAKE after one clocked cycle
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GATED = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_clk_en;
   logic             r_gated;
   logic             r_ready;
   logic             r_drain_req;
   logic             w_stay;
   logic             w_wake_cond;
   logic             w_in_drain;

   assign w_stay      = enable_i & ~test_mode_i & ~busy_i & ~wake_req_i;
   assign w_wake_cond = wake_req_i | ~enable_i | test_mode_i;
   assign w_in_drain  = (r_state == ST_DRAIN);

   // Next-state and shared idle/wake counter
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (!w_stay) begin
               w_cnt_nxt = {CNT_W{1'b0}};
            end else if (r_cnt == IDLE_LAST) begin
               w_state_nxt = ST_DRAIN;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            // Abort has priority over a simultaneous acknowledge
            if (!w_stay) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else if (drain_ack_i) begin
               w_state_nxt = ST_GATED;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_GATED: begin
            if (w_wake_cond) begin
               w_state_nxt = ST_WAKE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = ST_GATED;
            end
         end
         ST_WAKE: begin
            if (r_cnt >= WAKE_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, counter and registered outputs decoded from the next state
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= ST_RUN;
         r_cnt       <= {CNT_W{1'b0}};
         r_clk_en    <= 1'b1;
         r_gated     <= 1'b0;
         r_ready     <= 1'b1;
         r_drain_req <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_clk_en    <= (w_state_nxt != ST_GATED);
         r_gated     <= (w_state_nxt == ST_GATED);
         r_ready     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
         r_drain_req <= (w_state_nxt == ST_DRAIN);
      end
   end

   assign clk_en_o    = r_clk_en;
   assign gated_o     = r_gated;
   assign ready_o     = r_ready;
   assign drain_req_o = r_drain_req;
   assign test_en_o   = test_mode_i;

   clock_gate_ctrl_chk u_chk (
      .i_clk       (clk_i),
      .i_rst_n     (rst_ni),
      .i_drain_ack (drain_ack_i),
      .i_in_drain  (w_in_drain)
   );

endmodule
